// File: rtl/cpu_types_pkg.sv
// Shared datapath types: machine word, RAM handshake state and the memory
// arbiter's state encoding.
package cpu_types_pkg;

  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IGRANT = 2'd1,
    DGRANT = 2'd2
  } arb_state_t;

endpackage

// File: rtl/memory_arbiter.sv
// Shares one single-ported RAM between instruction fetch and data memory.
// Data wins ties; a saturating streak counter forces a fetch through after STARVE_MAX data grants.
module memory_arbiter
  import cpu_types_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  ramstate_t   ramstate,
  output logic [1:0]  dbg_state,
  output logic [3:0]  dbg_streak
);

  localparam int SW = $clog2(STARVE_MAX + 1);

  // Handshake: a requester raises its enable(s) and holds address/data steady;
  // the access completes in the one cycle its wait is low, then the enable may drop.
  arb_state_t    state;
  arb_state_t    next_state;
  logic [SW-1:0] streak;
  logic          i_done;
  logic          d_done;
  logic          d_req;
  logic          starved;

  assign d_req   = dREN | dWEN;
  assign starved = iREN && (streak == SW'(STARVE_MAX));

  always_comb begin
    next_state = state;
    ramREN     = 1'b0;
    ramWEN     = 1'b0;
    ramaddr    = '0;
    ramstore   = '0;
    i_done     = 1'b0;
    d_done     = 1'b0;
    case (state)
      IDLE: begin
        if (d_req && !starved) begin
          next_state = DGRANT;
        end else if (iREN) begin
          next_state = IGRANT;
        end
      end
      IGRANT: begin
        ramREN  = iREN;
        ramaddr = iaddr;
        if (!iREN) begin
          next_state = IDLE;
        end else if (ramstate == ACCESS) begin
          i_done     = 1'b1;
          next_state = IDLE;
        end
      end
      DGRANT: begin
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
        ramaddr  = daddr;
        ramstore = dstore;
        if (!d_req) begin
          next_state = IDLE;
        end else if (ramstate == ACCESS) begin
          d_done     = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  assign iwait      = ~i_done;
  assign dwait      = ~d_done;
  assign iload      = ramload;
  assign dload      = ramload;
  assign dbg_state  = state;
  assign dbg_streak = 4'(streak);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state  <= IDLE;
      streak <= '0;
    end else begin
      state <= next_state;
      if (i_done || (state == IDLE && !iREN)) begin
        streak <= '0;
      end else if (d_done && iREN && streak != SW'(STARVE_MAX)) begin
        streak <= streak + SW'(1);
      end
    end
  end

endmodule

// File: doc/memory_arbiter.md
# memory_arbiter

Sequential arbiter that shares the single-ported RAM between the instruction-fetch path and the data-memory path of the pipelined datapath. It sits between the datapath's cache-side requests and the RAM. It grants one requester at a time and holds the grant until the RAM reports completion. Data requests win ties, and a bounded streak counter keeps instruction fetch from starving.

## Interface
- STARVE_MAX, 4: consecutive data grants allowed while an instruction request waits; legal range 1..15.

- CLK  in  1  clock; all state updates on the rising edge.
- nRST  in  1  reset, asynchronous, active-low.
- iREN  in  1  instruction read request.
- iaddr  in  32  instruction address.
- iwait  out  1  low for exactly the completion cycle of an instruction grant.
- iload  out  32  instruction word; valid when iwait is low.
- dREN  in  1  data read request.
- dWEN  in  1  data write request.
- daddr  in  32  data address.
- dstore  in  32  write data.
- dwait  out  1  low for exactly the completion cycle of a data grant.
- dload  out  32  read data; valid when dwait is low.
- ramREN  out  1  RAM read enable.
- ramWEN  out  1  RAM write enable.
- ramaddr  out  32  RAM address.
- ramstore  out  32  RAM write data.
- ramload  in  32  RAM read data.
- ramstate  in  ramstate_t  FREE / BUSY / ACCESS / ERROR.

## Operation
- State machine with states IDLE, IGRANT and DGRANT. The state register is reset to IDLE.
- **IDLE**
  - RAM enables are 0 and both waits are 1.
  - Arbitration runs here, with this priority:
    - If (dREN|dWEN) and not (iREN and streak==STARVE_MAX), go to DGRANT.
    - Otherwise, if iREN, go to IGRANT.
    - Otherwise, stay in IDLE.
- **IGRANT**
  - ramREN=iREN, ramWEN=0, ramaddr=iaddr.
  - When ramstate==ACCESS, iwait=0 and iload=ramload, then go to IDLE.
  - If iREN drops before ACCESS, go to IDLE; the enables drop combinationally the same cycle.
- **DGRANT**
  - ramWEN=dWEN, ramREN=dREN & ~dWEN (a write wins if both are set), ramaddr=daddr, ramstore=dstore.
  - When ACCESS arrives, dwait=0 and dload=ramload, then go to IDLE.
  - If dREN and dWEN both drop before ACCESS, go to IDLE.
- **ramstate handling**
  - BUSY, FREE and ERROR all hold the current grant, with waits high. ERROR is a RAM-side retry; the arbiter takes no other action.
- **Signals outside a grant**
  - The waits of the non-granted requester stay 1 in every state.
  - iload and dload equal ramload at all times; they are meaningful only when the corresponding wait is low.
  - ramaddr and ramstore are 0 in IDLE.
- **streak counter**
  - Width $clog2(STARVE_MAX+1); reset value 0.
  - Incremented on DGRANT completion while iREN=1, saturating at STARVE_MAX.
  - Cleared on IGRANT completion, and cleared at any IDLE cycle where iREN=0.
- **Reset mid-operation:** the state machine returns to IDLE and streak clears immediately (asynchronously). Any in-flight RAM access is abandoned because the enables drop at once.

## Timing
- Request seen in IDLE at cycle 0. Grant state is registered at the end of cycle 0. RAM enables assert in cycle 1.
- A RAM with ACCESS in its first granted cycle completes in cycle 1, giving a 2-cycle request-to-data latency.
- The wait signals are combinational from ramstate in the grant state; there is no registered output delay.
- There is one mandatory IDLE turnaround cycle after every completion. The maximum throughput is therefore one transaction per 2 cycles when the RAM has zero wait states.
- Requesters hold their address, store data and enables stable from request until they see wait low.
- Reset values: ramREN=0, ramWEN=0, ramaddr=0, ramstore=0, iwait=1, dwait=1.

## Structure
- cpu_types_pkg supplies word_t (32-bit) and ramstate_t. The new arb_state_t enum (IDLE, IGRANT, DGRANT) is added to cpu_types_pkg.
- Single module, with no sub-module:
  - a state register plus streak counter in one always_ff;
  - next-state logic and output muxing in always_comb.

## Test plan
- **Reset:** assert nRST=0 mid-DGRANT (ramstate BUSY) -> ramWEN=0, dwait=1 and iwait=1 in the same cycle. After release the state is IDLE and streak is 0.
- **Single fetch:** iREN=1, iaddr=0x40, ramstate ACCESS in cycle 1 with ramload=0x8C220004 -> ramREN=1 and ramaddr=0x40 in cycle 1, iwait=0 and iload=0x8C220004 in cycle 1, iwait=1 in cycle 2.
- **Tie:** iREN=1, dWEN=1, daddr=0x100, dstore=0xDEADBEEF, RAM with 2 BUSY cycles before ACCESS -> DGRANT first, dwait=0 in cycle 3. IGRANT follows after one IDLE cycle.
- **Starvation:** iREN held, dREN re-asserted continuously, STARVE_MAX=4 -> exactly 4 data completions, then an instruction grant, then streak returns to 0.
- **Drop:** dREN asserted, then deasserted in cycle 2 while ramstate is BUSY -> ramREN=0 in cycle 2, IDLE in cycle 3, no dwait pulse.
- **Read/write conflict:** dREN=dWEN=1 -> ramWEN=1, ramREN=0 throughout the grant.
